instruction_fetch_unit: RTL and testbench

- Fetch stage directly downstream of the PC register in the RV32I CPU.
- Consumes the registered PC, issues word reads to instruction memory and holds the returned instruction for decode under a valid/ready handshake.
- Drives the PC register's load/in pair for sequential advance (PC+4) and for execute-stage redirects.
- Kills a stale in-flight read after a redirect.

---
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage between the PC register and decode: issues word reads to
// instruction memory, holds the result for decode, and steers the PC register.
module instruction_fetch_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_next,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_address,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_resp,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [31:0]      fetch_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] drain_addr;
  logic [WIDTH-1:0] fetch_addr;
  logic [WIDTH-1:0] target_addr;
  logic             capture;
  logic             flush;
  logic             xfer;
  logic             save_drain;

  assign fetch_addr  = {pc_in[WIDTH-1:2], 2'b00};
  assign target_addr = {redirect_target[WIDTH-1:2], 2'b00};

  // State register and datapath; async reset drops any in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      fetch_count <= '0;
      drain_addr  <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc_in;
      end else if (flush) begin
        instr <= NOP_INSTR;
      end
      if (xfer)       fetch_count <= fetch_count + CNT_W'(1);
      if (save_drain) drain_addr  <= fetch_addr;
    end
  end

  // Next state and handshake outputs; redirect always overrides advance/transfer
  always_comb begin
    state_nxt    = state;
    imem_read    = 1'b0;
    imem_address = fetch_addr;
    pc_load      = 1'b0;
    pc_next      = pc_in + WIDTH'(4);
    instr_valid  = 1'b0;
    capture      = 1'b0;
    flush        = 1'b0;
    xfer         = 1'b0;
    save_drain   = 1'b0;

    if (!rst) begin
      unique case (state)
        FETCH: begin
          imem_read = 1'b1;
          if (redirect) begin
            pc_load = 1'b1;
            pc_next = target_addr;
            if (!imem_resp) begin
              save_drain = 1'b1;
              state_nxt  = DRAIN;
            end
          end else if (imem_resp) begin
            pc_load   = 1'b1;
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          instr_valid = !redirect;
          if (redirect) begin
            pc_load   = 1'b1;
            pc_next   = target_addr;
            flush     = 1'b1;
            state_nxt = FETCH;
          end else if (instr_ready) begin
            xfer      = 1'b1;
            state_nxt = FETCH;
          end
        end
        DRAIN: begin
          imem_read    = 1'b1;
          imem_address = drain_addr;
          if (redirect) begin
            pc_load = 1'b1;
            pc_next = target_addr;
          end
          // The stale read still completes even if a new redirect lands with it
          if (imem_resp) state_nxt = FETCH;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural PC register
// (reset value 0x60) closing the pc_load/pc_next loop.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_load         (pc_load),
    .pc_next         (pc_next),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_read       (imem_read),
    .imem_address    (imem_address),
    .imem_rdata      (imem_rdata),
    .imem_resp       (imem_resp),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  // PC register the fetch unit drives
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc_in <= 32'h0000_0060;
    else if (pc_load) pc_in <= pc_next;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [31:0] tgt, input logic resp,
                       input logic [31:0] rdata, input logic rdy);
    redirect        = rd;
    redirect_target = tgt;
    imem_resp       = resp;
    imem_rdata      = rdata;
    instr_ready     = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("rst_read", 32'(imem_read), 32'd0);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_count", fetch_count, 32'h0);

    // First fetch: 0x60 held for 4 cycles, response on the 4th
    #10;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_read", 32'(imem_read), 32'd1);
      chk("wait_addr", imem_address, 32'h60);
      chk("wait_valid", 32'(instr_valid), 32'd0);
      chk("wait_pc_load", 32'(pc_load), 32'd0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h0050_0093, 1'b0);
    chk("resp_addr", imem_address, 32'h60);
    chk("resp_pc_load", 32'(pc_load), 32'd1);
    chk("resp_pc_next", pc_next, 32'h64);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("hold_valid", 32'(instr_valid), 32'd1);
    chk("hold_instr", instr, 32'h0050_0093);
    chk("hold_instr_pc", instr_pc, 32'h60);
    chk("hold_pc_load", 32'(pc_load), 32'd0);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, 32'h0050_0093);
      chk("stall_instr_pc", instr_pc, 32'h60);
      chk("stall_read", 32'(imem_read), 32'd0);
      chk("stall_count", fetch_count, 32'd0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("accept_valid", 32'(instr_valid), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("accept_count", fetch_count, 32'd1);
    chk("next_read", 32'(imem_read), 32'd1);
    chk("next_addr", imem_address, 32'h64);

    // Redirect to 0x200 while 0x64 is pending: drain the stale read
    drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    chk("redir_pc_load", 32'(pc_load), 32'd1);
    chk("redir_pc_next", pc_next, 32'h200);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("drain_addr0", imem_address, 32'h64);
    chk("drain_read0", 32'(imem_read), 32'd1);
    tick();
    chk("drain_addr1", imem_address, 32'h64);
    chk("drain_valid", 32'(instr_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("drain_resp_addr", imem_address, 32'h64);
    chk("drain_resp_pc_load", 32'(pc_load), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("post_drain_addr", imem_address, 32'h200);
    chk("post_drain_valid", 32'(instr_valid), 32'd0);
    chk("post_drain_instr", instr, 32'h0050_0093);

    // Fetch 0x200, then redirect and ready in the same HOLD cycle
    drive(1'b0, 32'h0, 1'b1, 32'h0010_0113, 1'b0);
    chk("f200_pc_next", pc_next, 32'h204);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("f200_valid", 32'(instr_valid), 32'd1);
    chk("f200_instr_pc", instr_pc, 32'h200);
    drive(1'b1, 32'h302, 1'b0, 32'h0, 1'b1);
    chk("hold_redir_valid", 32'(instr_valid), 32'd0);
    chk("hold_redir_pc_load", 32'(pc_load), 32'd1);
    chk("hold_redir_pc_next", pc_next, 32'h300);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("hold_redir_count", fetch_count, 32'd1);
    chk("hold_redir_instr", instr, NOP);
    chk("hold_redir_addr", imem_address, 32'h300);
    chk("hold_redir_read", 32'(imem_read), 32'd1);

    // Redirect and response together in FETCH
    drive(1'b1, 32'h404, 1'b1, 32'h1234_5678, 1'b0);
    chk("same_pc_next", pc_next, 32'h404);
    chk("same_pc_load", 32'(pc_load), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("same_read", 32'(imem_read), 32'd1);
    chk("same_addr", imem_address, 32'h404);
    chk("same_valid", 32'(instr_valid), 32'd0);
    chk("same_instr", instr, NOP);

    // PC wrap at the top of the address space
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0073, 1'b0);
    chk("wrap_addr", imem_address, 32'hFFFF_FFFC);
    chk("wrap_pc_next", pc_next, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", instr, 32'h0000_0073);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("wrap_count", fetch_count, 32'd2);
    chk("wrap_next_addr", imem_address, 32'h0);

    // Enter DRAIN, redirect again inside it, then reset mid-drain
    drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    chk("drain2_pc_load", 32'(pc_load), 32'd1);
    chk("drain2_pc_next", pc_next, 32'h600);
    chk("drain2_addr", imem_address, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("drain2_stay_read", 32'(imem_read), 32'd1);
    chk("drain2_stay_addr", imem_address, 32'h0);
    chk("drain2_pc", pc_in, 32'h600);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_read", 32'(imem_read), 32'd0);
    chk("mid_rst_pc_load", 32'(pc_load), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_instr", instr, NOP);
    chk("mid_rst_instr_pc", instr_pc, 32'h0);
    chk("mid_rst_count", fetch_count, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("after_rst_read", 32'(imem_read), 32'd1);
    chk("after_rst_addr", imem_address, 32'h60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
